// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream FIFO and sends each as an 8N1 UART frame.
// fifo_rd is the only combinational output; tx, busy and tx_done decode registered state.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              baud_end;

  // Last cycle of the current UART bit period.
  assign baud_end = (baud_cnt == BAUD_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the FIFO flags are only looked at while idle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en && !fifo_empty) state_next = FETCH;
      FETCH:   state_next = START;
      START:   if (baud_end) state_next = DATA;
      DATA:    if (baud_end && (bit_cnt == BIT_LAST)) state_next = STOP;
      STOP:    if (baud_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the registered state, plus the Mealy pop request in IDLE.
  always_comb begin
    fifo_rd = 1'b0;
    tx      = 1'b1;
    busy    = 1'b1;
    tx_done = 1'b0;
    case (state)
      IDLE: begin
        busy    = 1'b0;
        fifo_rd = en & ~fifo_empty;
      end
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      STOP:    tx_done = baud_end;
      default: ;
    endcase
  end

  // Baud counter, bit counter and shift register; byte is captured as FETCH closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        FETCH: begin
          shift    <= fifo_dout;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
        START, STOP: begin
          baud_cnt <= baud_end ? '0 : baud_cnt + BAUD_W'(1);
        end
        DATA: begin
          baud_cnt <= baud_end ? '0 : baud_cnt + BAUD_W'(1);
          if (baud_end) begin
            shift   <= {1'b0, shift[DATA_W-1:1]};
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        default: begin
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed and random stimulus for fifo_uart_tx against a frame-level model.
module tb_fifo_uart_tx;

  localparam int C     = 4;
  localparam int C2    = 2;
  localparam int FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       rst, en, en2, fifo_empty, fifo_empty2;
  logic [7:0] fifo_dout, fifo_dout2;
  logic       fifo_rd, tx, busy, tx_done;
  logic       fifo_rd2, tx2, busy2, tx_done2;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(C2), .DATA_W(8)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .fifo_empty(fifo_empty2), .fifo_dout(fifo_dout2),
    .fifo_rd(fifo_rd2), .tx(tx2), .busy(busy2), .tx_done(tx_done2)
  );

  int         compared = 0;
  int         mismatched = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         m_c = -1;      // cycles since FETCH, -1 when idle
  logic [7:0] m_byte = 8'h00;
  int         pop_cnt, done_cnt, underflow;
  logic       rx_on, rx_prev;
  int         rx_cnt;
  logic [7:0] rx_sh;
  logic       rec2;
  logic       tr_tx2[$];
  logic       tr_done2[$];
  logic       tr_rd2[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level c cycles after FETCH for byte b (frame: start, 8 data LSB first, stop).
  function automatic logic exp_tx_of(input int c, input logic [7:0] b);
    int k;
    if (c <= 0) return 1'b1;
    k = (c - 1) / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic push1(input logic [7:0] b);
    q1.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, advance model and receiver, service FIFO pops.
  task automatic step();
    logic e_rd, e_busy, e_done, e_tx, rd1, rd2, line;
    int   k;
    #1;
    e_rd   = (m_c < 0) && en && (q1.size() != 0);
    e_busy = (m_c >= 0);
    e_done = (m_c == FRAME);
    e_tx   = exp_tx_of(m_c, m_byte);
    chk("tx", 32'(tx), 32'(e_tx));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("tx_done", 32'(tx_done), 32'(e_done));
    chk("fifo_rd", 32'(fifo_rd), 32'(e_rd));
    rd1  = fifo_rd;
    rd2  = fifo_rd2;
    line = tx;
    if (rd1) pop_cnt++;
    if (tx_done) done_cnt++;
    if (rx_on) begin
      rx_cnt++;
      if ((rx_cnt % C) == (C / 2)) begin
        k = rx_cnt / C;
        if (k >= 1 && k <= 8) begin
          rx_sh[k-1] = line;
        end else if (k == 9) begin
          chk("stop_bit", 32'(line), 32'd1);
          rx_q.push_back(rx_sh);
          rx_on = 1'b0;
        end
      end
    end else if (!line && rx_prev) begin
      rx_on  = 1'b1;
      rx_cnt = 0;
    end
    rx_prev = line;
    if (rst) rx_on = 1'b0;
    if (rst) begin
      m_c = -1;
    end else if (m_c < 0) begin
      if (e_rd) begin
        m_c    = 0;
        m_byte = q1[0];
      end
    end else if (m_c == FRAME) begin
      m_c = -1;
    end else begin
      m_c++;
    end
    if (rec2) begin
      tr_tx2.push_back(tx2);
      tr_done2.push_back(tx_done2);
      tr_rd2.push_back(rd2);
    end else begin
      chk("tx2_idle", 32'(tx2), 32'd1);
      chk("busy2_idle", 32'(busy2), 32'd0);
    end
    @(posedge clk);
    #1;
    if (rd1) begin
      if (q1.size() == 0) underflow++;
      else fifo_dout = q1.pop_front();
      fifo_empty = (q1.size() == 0);
    end
    if (rd2) begin
      if (q2.size() == 0) underflow++;
      else fifo_dout2 = q2.pop_front();
      fifo_empty2 = (q2.size() == 0);
    end
    @(negedge clk);
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((m_c >= 0 || (en && q1.size() != 0)) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < maxc), 32'd1);
  endtask

  task automatic wait_mc(input int target, input int maxc);
    int n;
    n = 0;
    while (m_c != target && n < maxc) begin
      step();
      n++;
    end
    chk("wait_timeout", 32'(m_c == target), 32'd1);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    int         p, npop;
    rst = 1'b1; en = 1'b1; en2 = 1'b0;
    fifo_empty = 1'b1; fifo_empty2 = 1'b1;
    fifo_dout = 8'h00; fifo_dout2 = 8'h00;
    rec2 = 1'b0; rx_on = 1'b0; rx_prev = 1'b1; rx_cnt = 0; rx_sh = 8'h00;
    pop_cnt = 0; done_cnt = 0; underflow = 0;
    @(posedge clk);
    @(negedge clk);

    // Reset hold with an empty FIFO, then idle.
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();
    chk("p1_pops", 32'(pop_cnt), 32'd0);

    // Single byte.
    pop_cnt = 0; done_cnt = 0;
    push1(8'hA5); exp_q.push_back(8'hA5);
    drain(200);
    chk("p2_pops", 32'(pop_cnt), 32'd1);
    chk("p2_done", 32'(done_cnt), 32'd1);
    check_rx("p2");

    // Back-to-back 16 bytes.
    pop_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      push1(8'(i));
      exp_q.push_back(8'(i));
    end
    drain(16 * (FRAME + 2) + 50);
    chk("p3_pops", 32'(pop_cnt), 32'd16);
    chk("p3_done", 32'(done_cnt), 32'd16);
    chk("p3_underflow", 32'(underflow), 32'd0);
    check_rx("p3");

    // Pause during data bit 3.
    pop_cnt = 0; done_cnt = 0;
    push1(8'h3C); push1(8'h11);
    exp_q.push_back(8'h3C); exp_q.push_back(8'h11);
    wait_mc(1 + 4 * C + 1, 100);
    en = 1'b0;
    drain(100);
    chk("p4_pops_paused", 32'(pop_cnt), 32'd1);
    repeat (10) step();
    chk("p4_pops_hold", 32'(pop_cnt), 32'd1);
    en = 1'b1;
    step();
    chk("p4_pop_on_en", 32'(pop_cnt), 32'd2);
    drain(200);
    chk("p4_done", 32'(done_cnt), 32'd2);
    check_rx("p4");

    // Reset during data bit 5.
    pop_cnt = 0; done_cnt = 0;
    push1(8'h5A); push1(8'h77);
    exp_q.push_back(8'h77);
    wait_mc(1 + 6 * C + 1, 100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("p5_no_done", 32'(done_cnt), 32'd0);
    drain(200);
    chk("p5_pops", 32'(pop_cnt), 32'd2);
    chk("p5_done", 32'(done_cnt), 32'd1);
    check_rx("p5");

    // Random pushes with random enable.
    pop_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        b = 8'($urandom);
        push1(b);
        exp_q.push_back(b);
      end
      en = ($urandom_range(0, 4) != 0);
      step();
    end
    en = 1'b1;
    drain(200 * (FRAME + 2));
    chk("p6_pops", 32'(pop_cnt), 32'(exp_q.size()));
    chk("p6_done", 32'(done_cnt), 32'(exp_q.size()));
    chk("p6_underflow", 32'(underflow), 32'd0);
    check_rx("p6");

    // Two-cycle bit period with 0xFF.
    rec2 = 1'b1;
    q2.push_back(8'hFF);
    fifo_empty2 = 1'b0;
    en2 = 1'b1;
    repeat (3) step();
    en2 = 1'b0;
    repeat (27) step();
    rec2 = 1'b0;
    p = -1;
    npop = 0;
    for (int i = 0; i < tr_rd2.size(); i++) begin
      if (tr_rd2[i]) begin
        npop++;
        if (p < 0) p = i;
      end
    end
    chk("p7_pop_index", 32'(p), 32'd0);
    chk("p7_pops", 32'(npop), 32'd1);
    if (p >= 0 && p + 22 < tr_tx2.size()) begin
      for (int j = 1; j <= 22; j++) begin
        chk("p7_tx", 32'(tr_tx2[p+j]), (j == 2 || j == 3) ? 32'd0 : 32'd1);
        chk("p7_done", 32'(tr_done2[p+j]), (j == 21) ? 32'd1 : 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
